// File: rtl/dff_pattern_checker.sv
// dff_pattern_checker: drives a flip-flop under test with an LFSR bit stream
// and checks its q/qbar one cycle later, reporting errors and first failing index.
module dff_pattern_checker #(
    parameter int unsigned N_VECTORS = 16,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       d_out,
    input  logic       q_in,
    input  logic       qbar_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // an all-zero LFSR would lock up, so a zero seed is promoted to 1
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] vec_idx_q, vec_idx_d;
    logic [7:0] exp_idx_q, exp_idx_d;
    logic [7:0] err_q, err_d;
    logic [7:0] fei_q, fei_d;
    logic       exp_q, exp_d;
    logic       chk_q, chk_d;
    logic       fail;
    logic       launch;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        vec_idx_d = vec_idx_q;
        exp_idx_d = exp_idx_q;
        exp_d     = exp_q;
        chk_d     = chk_q;
        err_d     = err_q;
        fei_d     = fei_q;
        launch    = start && (state_q == IDLE || state_q == DONE);
        fail      = chk_q && (state_q == RUN || state_q == DRAIN) &&
                    (q_in != exp_q || qbar_in == q_in);
        if (fail) begin
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            fei_d = (fei_q == 8'hFF) ? exp_idx_q : fei_q;
        end
        if (state_q == RUN) begin
            lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            exp_d     = lfsr_q[7];
            exp_idx_d = vec_idx_q;
            chk_d     = 1'b1;
            vec_idx_d = vec_idx_q + 8'd1;
            state_d   = (vec_idx_q == LAST_IDX) ? DRAIN : RUN;
        end
        if (state_q == DRAIN) begin
            state_d = DONE;
            chk_d   = 1'b0;
        end
        if (launch) begin
            state_d   = RUN;
            lfsr_d    = SEED_EFF;
            vec_idx_d = 8'd0;
            err_d     = 8'd0;
            fei_d     = 8'hFF;
            chk_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= 8'h01;
            vec_idx_q <= 8'd0;
            exp_idx_q <= 8'd0;
            exp_q     <= 1'b0;
            chk_q     <= 1'b0;
            err_q     <= 8'd0;
            fei_q     <= 8'hFF;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            vec_idx_q <= vec_idx_d;
            exp_idx_q <= exp_idx_d;
            exp_q     <= exp_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
            fei_q     <= fei_d;
        end
    end

    assign d_out         = (state_q == RUN) && lfsr_q[7];
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_q == 8'd0);
    assign err_count     = err_q;
    assign first_err_idx = fei_q;
endmodule

// File: tb/tb_dff_pattern_checker.sv
// tb_dff_pattern_checker: scoreboard bench with a behavioural flip-flop that can
// be made faulty, plus a second instance for the N_VECTORS=1 / zero-seed corner.
module tb_dff_pattern_checker;
    localparam int N = 16;

    typedef struct {
        int err;
        int fei;
        int pass;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       q, qbar, q2, qbar2;
    logic       d_out, busy, done, pass;
    logic       d2, busy2, done2, pass2;
    logic [7:0] err_count, fei, err2, fei2;

    int   total = 0;
    int   bad = 0;
    int   cyc;
    int   mode = 0;
    int   fidx = 5;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    res_t res_q[$];
    bit   dq[$];

    always #5 clk = ~clk;

    dff_pattern_checker dut (
        .clk(clk), .rst(rst), .start(start), .d_out(d_out), .q_in(q), .qbar_in(qbar),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_idx(fei)
    );

    dff_pattern_checker #(.N_VECTORS(1), .SEED(8'h00)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .d_out(d2), .q_in(q2), .qbar_in(qbar2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_idx(fei2)
    );

    // run cycle index as seen by the bench: 0 is the first cycle after an accepted start
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 999;
        else if (start && !busy) cyc <= 0;
        else if (cyc < 999) cyc <= cyc + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0; qbar <= 1'b1; q2 <= 1'b0; qbar2 <= 1'b1;
        end else begin
            q     <= (mode == 1) ? 1'b0 : d_out;
            qbar  <= (mode == 1) ? 1'b1 : (mode == 2 && cyc == fidx) ? d_out : ~d_out;
            q2    <= d2;
            qbar2 <= ~d2;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input int m, input int fi);
        res_t r;
        logic [7:0] l = 8'hA5;
        int ones = 0;
        int first = 255;
        mode = m;
        fidx = fi;
        for (int i = 0; i < N; i++) begin
            dq.push_back(l[7]);
            if (l[7]) begin
                ones++;
                if (first == 255) first = i;
            end
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        r.err  = (m == 1) ? ones : (m == 2) ? 1 : 0;
        r.fei  = (m == 1) ? first : (m == 2) ? fi : 255;
        r.pass = (r.err == 0) ? 1 : 0;
        res_q.push_back(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for done", nm);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_dout"}, int'(d_out), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_pass"}, int'(pass), 0);
        chk({nm, "_err"}, int'(err_count), 0);
        chk({nm, "_fei"}, int'(fei), 255);
    endtask

    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                done_prev = 1'b0;
            end else begin
                if (busy && cyc < N) begin
                    if (dq.size() == 0) chk("dout_underflow", 1, 0);
                    else chk("d_out", int'(d_out), int'(dq.pop_front()));
                end else chk("d_out_idle", int'(d_out), 0);
                if (busy) busy_cnt++;
                if (done && !done_prev) begin
                    if (res_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        r = res_q.pop_front();
                        chk("err_count", int'(err_count), r.err);
                        chk("first_err_idx", int'(fei), r.fei);
                        chk("pass", int'(pass), r.pass);
                        chk("busy_len", busy_cnt, N + 1);
                        chk("done_cycle", cyc, N + 1);
                    end
                    busy_cnt = 0;
                end
                done_prev = done;
            end
        end
    end

    initial begin : stim
        int n;
        #3 rst = 1'b1;
        #1 check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(0, 0);
        wait_done("ideal");
        issue(1, 0);
        wait_done("stuck");
        issue(2, 5);
        chk("b2b_done_drop", int'(done), 0);
        chk("b2b_err_clear", int'(err_count), 0);
        chk("b2b_busy", int'(busy), 1);
        wait_done("qbar5");

        issue(0, 0);
        n = 0;
        while (cyc != 8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_cycle8", cyc, 8);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        res_q.delete();
        dq.delete();
        busy_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 0);
        wait_done("rerun");

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("n1_first_dout", int'(d2), 0);
        chk("n1_busy_c0", int'(busy2), 1);
        @(negedge clk);
        chk("n1_busy_c1", int'(busy2), 1);
        chk("n1_done_c1", int'(done2), 0);
        @(negedge clk);
        chk("n1_done_c2", int'(done2), 1);
        chk("n1_pass", int'(pass2), 1);
        chk("n1_err", int'(err2), 0);
        chk("n1_fei", int'(fei2), 255);

        for (int it = 0; it < 10; it++) begin
            issue($urandom_range(0, 2), $urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done("random");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("res_queue_empty", res_q.size(), 0);
        chk("dout_queue_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dff_pattern_checker.md
# dff_pattern_checker

Self-checking driver/monitor that sits across a single D flip-flop under test (same clock domain) in the lab datapath. It drives the flip-flop's data input with a pseudo-random bit stream from an 8-bit LFSR and reads back the flip-flop's q/qbar one cycle later. It compares them against its own registered copy of the expected value and reports pass/fail, an error count and the index of the first failing vector. This replaces hand-written stimulus with an on-chip check of any flip-flop variant the team builds.

## Interface
- N_VECTORS, 16, number of bits driven per run; legal range 1..255
- SEED, 8'hA5, LFSR load value at start; a value of 8'h00 is loaded as 8'h01

- clk  input  1  rising-edge clock, shared with the flip-flop under test
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE
- d_out  output  1  data driven to the flip-flop's d input
- q_in  input  1  flip-flop q output
- qbar_in  input  1  flip-flop qbar output
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE, held until the next start or reset
- pass  output  1  done && err_count == 0
- err_count  output  8  number of failing vectors in the run; saturates at 255
- first_err_idx  output  8  index of the first failing vector; 8'hFF if there is none

## Operation
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after N_VECTORS cycles.
  - DRAIN -> DONE after 1 cycle.
  - DONE -> RUN on start.
  - start in RUN or DRAIN is ignored.
- On the start edge:
  - lfsr <= SEED (8'h01 if SEED is 0)
  - vec_idx <= 0
  - err_count <= 0
  - first_err_idx <= 8'hFF
  - chk_valid <= 0
- LFSR: d_out = lfsr[7]. In RUN, each cycle lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- d_out is driven from lfsr[7] only in RUN; it is 0 in every other state.
- Expected value: in RUN, each edge registers exp <= d_out, exp_idx <= vec_idx, chk_valid <= 1, and increments vec_idx.
- A vector fails when chk_valid is set and (q_in != exp or qbar_in != ~q_in).
- On a failing edge:
  - err_count increments, saturating at 255.
  - first_err_idx is written with exp_idx, but only if it still holds 8'hFF.
- Leaving DRAIN clears chk_valid. No checks occur in IDLE or DONE.
- Reset values:
  - state IDLE, lfsr 8'h01
  - d_out 0, busy 0, done 0, pass 0
  - err_count 0, first_err_idx 8'hFF
  - vec_idx 0, chk_valid 0
- Reset mid-run aborts immediately with the values above. No partial result is retained.

## Timing
- Cycle 0 is the first cycle after the start edge; RUN spans cycles 0..N_VECTORS-1.
  - During cycle k, d_out carries vector k.
  - The flip-flop captures vector k at the edge ending cycle k.
  - The checker compares q_in against vector k during cycle k+1 and updates its counters at the edge ending cycle k+1.
- DRAIN is cycle N_VECTORS; it checks vector N_VECTORS-1.
- done, pass, err_count and first_err_idx are final from cycle N_VECTORS+1. Latency from start to done is N_VECTORS+1 edges.
- err_count and first_err_idx may be read while busy, but they are valid only after done.
- Back-to-back runs: start in the first DONE cycle places RUN cycle 0 in the next cycle. done drops in that same cycle.
- Because there is no input synchronisation, q_in and qbar_in must come from flops on clk.

## Test plan
- Reset: assert rst asynchronously mid-cycle.
  - Outputs go to d_out 0, busy 0, done 0, pass 0, err_count 0, first_err_idx 8'hFF without waiting for a clock edge.
- Ideal flip-flop, N_VECTORS=16, SEED=8'hA5, one start pulse:
  - d_out sequence begins 1,0,1,0 (LFSR states A5, 4A, 95, 2A).
  - busy lasts 17 cycles; done is asserted at cycle 17.
  - pass=1, err_count=0, first_err_idx=8'hFF.
- q stuck at 0 (qbar stuck at 1), N_VECTORS=16, SEED=8'hA5:
  - err_count equals the number of 1s in the 16-bit sequence.
  - first_err_idx=0; pass=0.
- qbar forced equal to q on vector 5 only:
  - err_count=1, first_err_idx=5, pass=0.
- rst pulsed in RUN cycle 8, then a new start:
  - Immediate return to IDLE with busy 0.
  - The rerun restarts the sequence at 1,0,1,0 with cleared counts and a full 17-cycle run.
- Edge cases:
  - N_VECTORS=1: done at cycle 2.
  - start pulsed during RUN: ignored; run length is unchanged.
  - start asserted in DONE: the next run starts at once, and err_count clears to 0.
  - SEED=8'h00: behaves as SEED=8'h01, with the first d_out equal to 0.
